// File: rtl/issue_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one issue bus between N_REQ reservation stations.
// Latency: 1 cycle from request to out_valid when empty or when the consumer is ready.
// Backpressure: the output register holds while full and not ready; no acks are issued.
module issue_bus_arbiter #(
  parameter int XLEN   = 32,
  parameter int N_REQ  = 4,
  parameter int NAME_W = 8,
  parameter int TYPE_W = 4,
  parameter int INFO_W = 2*XLEN + NAME_W + 24 + TYPE_W + 5,
  parameter int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*INFO_W-1:0] req_info,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INFO_W-1:0]       out_info,
  output logic [SRC_W-1:0]        out_src
);

  // Field layout of one instruction record, MSB first.
  typedef struct packed {
    logic [XLEN-1:0]   address;
    logic [XLEN-1:0]   immediate;
    logic [NAME_W-1:0] instr_name;
    logic [23:0]       regs;
    logic [TYPE_W-1:0] instr_type;
    logic [4:0]        flags;
  } info_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  info_t            info_q, info_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;

  logic             cap;
  logic             found;
  logic [SRC_W-1:0] win;

  // Capture is possible when not flushing and the output slot is free or draining now.
  assign cap = !flush && ((state_q == EMPTY) || out_ready);

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = SRC_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot ack to the winner on a capture cycle; suppressed while reset is held.
  always_comb begin
    req_ack = '0;
    if (cap && found && !reset) begin
      req_ack[win] = 1'b1;
    end
  end

  // Next-state: flush clears, capture loads or empties, otherwise hold.
  always_comb begin
    state_d = state_q;
    info_d  = info_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (flush) begin
      state_d = EMPTY;
      info_d  = '0;
      src_d   = '0;
    end else if (cap) begin
      if (found) begin
        state_d = FULL;
        info_d  = info_t'(req_info[int'(win)*INFO_W +: INFO_W]);
        src_d   = win;
        ptr_d   = (win == SRC_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end else begin
        state_d = EMPTY;
        info_d  = '0;
        src_d   = '0;
      end
    end
  end

  // State and output register; reset discards any held record immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      info_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      info_q  <= info_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_info  = info_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_issue_bus_arbiter.sv
// Directed bench for issue_bus_arbiter with N_REQ=4 and default field widths.
module tb_issue_bus_arbiter;

  localparam int N      = 4;
  localparam int INFO_W = 105;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*INFO_W-1:0] req_info;
  logic [N-1:0]      req_ack;
  logic              out_valid;
  logic              out_ready;
  logic [INFO_W-1:0] out_info;
  logic [1:0]        out_src;

  int checks = 0;
  int errors = 0;

  issue_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_info  (req_info),
    .req_ack   (req_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_info  (out_info),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct record per requester index i and test tag t.
  function automatic logic [INFO_W-1:0] mk(input int i, input int t);
    mk = {32'hA000_0000 + 32'(t*256 + i), 32'h5A5A_0000 ^ 32'(i), 8'(i + 1),
          24'(t*4 + i), 4'(i + 1), 5'(t + 1)};
  endfunction

  task automatic set_recs(input int t);
    for (int i = 0; i < N; i++) req_info[i*INFO_W +: INFO_W] = mk(i, t);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; req_valid = 4'b1111;
    set_recs(1);
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (out_info !== '0) begin errors++; $display("FAIL reset_info: got %h exp 0", out_info); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b exp 0000", req_ack); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d exp 0", out_src); end
    tick();
    checks++; if (req_ack !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold: ack %b valid %b exp 0000 0", req_ack, out_valid); end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ack !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ack%0d: got %b exp %b", k, req_ack, 4'(1 << (k % 4))); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin errors++; $display("FAIL rr_src%0d: valid %b src %0d exp 1 %0d", k, out_valid, out_src, k % 4); end
      checks++; if (out_info !== mk(k % 4, 1)) begin errors++; $display("FAIL rr_info%0d: got %h exp %h", k, out_info, mk(k % 4, 1)); end
    end
    // ptr is now 1, register holds requester 0
  endtask

  task automatic test_backpressure();
    set_recs(2);
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL bp_fill_ack: got %b exp 0010", req_ack); end
    tick();
    checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL bp_fill_src: got %0d exp 1", out_src); end
    out_ready = 1'b0; req_valid = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL bp_ack%0d: got %b exp 0000", c, req_ack); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_info !== mk(1, 2)) begin
        errors++; $display("FAIL bp_hold%0d: valid %b src %0d info %h exp 1 1 %h", c, out_valid, out_src, out_info, mk(1, 2)); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL bp_release_ack: got %b exp 0100", req_ack); end
    tick();
    checks++; if (out_src !== 2'd2 || out_info !== mk(2, 2)) begin errors++; $display("FAIL bp_release_src: src %0d info %h exp 2 %h", out_src, out_info, mk(2, 2)); end
    // ptr is now 3
  endtask

  task automatic test_wrap();
    set_recs(3);
    req_valid = 4'b1001; out_ready = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL wrap_ack3: got %b exp 1000", req_ack); end
    tick();
    checks++; if (out_src !== 2'd3 || out_info !== mk(3, 3)) begin errors++; $display("FAIL wrap_src3: src %0d exp 3", out_src); end
    #1;
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0: got %b exp 0001", req_ack); end
    tick();
    checks++; if (out_src !== 2'd0 || out_info !== mk(0, 3)) begin errors++; $display("FAIL wrap_src0: src %0d exp 0", out_src); end
    // ptr is now 1
  endtask

  task automatic test_flush();
    req_valid = 4'b0010; out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL flush_ack: got %b exp 0000", req_ack); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_info !== '0 || out_src !== 2'd0) begin
      errors++; $display("FAIL flush_clear: valid %b src %0d info %h exp 0 0 0", out_valid, out_src, out_info); end
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL flush_regrant_ack: got %b exp 0010", req_ack); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin errors++; $display("FAIL flush_regrant_src: valid %b src %0d exp 1 1", out_valid, out_src); end
    // ptr is now 2
  endtask

  task automatic test_idle_drain();
    req_valid = 4'b0000; out_ready = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL idle_ack: got %b exp 0000", req_ack); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_info !== '0 || out_src !== 2'd0) begin
      errors++; $display("FAIL idle_clear: valid %b src %0d info %h exp 0 0 0", out_valid, out_src, out_info); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL idle_ptr_kept: got %b exp 0100", req_ack); end
    tick();
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL idle_next_src: got %0d exp 2", out_src); end
  endtask

  task automatic test_async_reset();
    set_recs(4);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_info !== '0) begin errors++; $display("FAIL areset_drop: valid %b info %h exp 0 0", out_valid, out_info); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL areset_ack: got %b exp 0000", req_ack); end
    tick();
    reset = 1'b0; req_valid = 4'b1010;
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL areset_first_ack: got %b exp 0010", req_ack); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_info !== mk(1, 4)) begin
      errors++; $display("FAIL areset_first_src: valid %b src %0d exp 1 1", out_valid, out_src); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_wrap();
    test_flush();
    test_idle_drain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
